// File: rtl/fib_pkg.sv
// Shared definitions for the Fibonacci generator and its stream buffer.
package fib_pkg;
    localparam int FIB_WIDTH     = 16;
    // Largest term count whose terms all fit in 16 bits without wrapping.
    localparam int FIB_MAX_TERMS = 25;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } fib_state_t;
endpackage

// File: rtl/fib_fifo.sv
// Show-ahead FIFO: head is the oldest entry. The caller gates push and pop.
module fib_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         head,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= push_data;
    end

    // Power-of-two depth lets the pointers wrap by natural overflow.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    assign empty = (count == '0);
    assign full  = (count == (AW+1)'(DEPTH));
    // Storage is not reset, so hide it while empty to give a clean zero.
    assign head  = empty ? '0 : mem[rd_ptr];
endmodule

// File: rtl/fib_stream_buffer.sv
// Paces the Fibonacci generator, captures its terms into a FIFO and stops
// after N_TERMS terms or when a 16-bit wrap-around is seen.
module fib_stream_buffer
    import fib_pkg::*;
#(
    parameter int WIDTH   = FIB_WIDTH,
    parameter int DEPTH   = 8,
    parameter int N_TERMS = FIB_MAX_TERMS
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    output logic                      f_en,
    input  logic                      f_valid,
    input  logic [WIDTH-1:0]          f_out,
    output logic                      m_valid,
    output logic [WIDTH-1:0]          m_data,
    input  logic                      m_ready,
    output logic [$clog2(DEPTH):0]    count,
    output logic                      busy,
    output logic                      done,
    output logic                      wrap_err
);
    fib_state_t       state;
    logic [15:0]      n;
    logic [WIDTH-1:0] last;
    logic             full;
    logic             empty;
    logic             capture;
    logic             is_wrap;
    logic             push;
    logic             pop;

    // Handshake: a term moves when f_valid && f_en; the head leaves when
    // m_valid && m_ready. Both may happen in the same cycle.
    assign f_en    = (state == RUN) && !full;
    assign capture = f_valid && f_en;
    // The opening 0, 1 pair is never checked; afterwards the sequence must rise.
    assign is_wrap = capture && (n >= 16'd2) && (f_out < last);
    assign push    = capture && !is_wrap;
    assign m_valid = !empty;
    assign pop     = m_valid && m_ready;
    assign busy    = (state == RUN);
    assign done    = (state == DONE);

    fib_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data (f_out),
        .pop       (pop),
        .head      (m_data),
        .count     (count),
        .full      (full),
        .empty     (empty)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            n        <= '0;
            last     <= '0;
            wrap_err <= 1'b0;
        end else begin
            if (push) begin
                n    <= n + 16'd1;
                last <= f_out;
            end
            case (state)
                IDLE: if (start) state <= RUN;
                RUN: begin
                    if (is_wrap) begin
                        wrap_err <= 1'b1;
                        state    <= DONE;
                    end else if (push && (n == 16'(N_TERMS - 1))) begin
                        state <= DONE;
                    end
                end
                // DONE holds until reset; the generator cannot be rewound otherwise.
                default: state <= state;
            endcase
        end
    end
endmodule

// File: tb/tb_fib_stream_buffer.sv
// Randomized scoreboard bench for fib_stream_buffer with a behavioural generator.
module tb_fib_stream_buffer;
    localparam int W  = 16;
    localparam int D  = 8;
    localparam int CW = $clog2(D) + 1;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic          m_ready = 1'b0;
    logic          f_en, f_valid, m_valid, busy, done, wrap_err;
    logic [W-1:0]  f_out, m_data;
    logic [CW-1:0] count;

    logic          start_w = 1'b0;
    logic          m_ready_w = 1'b1;
    logic          f_en_w, f_valid_w, m_valid_w, busy_w, done_w, wrap_err_w;
    logic [W-1:0]  f_out_w, m_data_w;
    logic [CW-1:0] count_w;

    logic [W-1:0]  ga, gb, ga_w, gb_w;
    logic [W-1:0]  exp_q[$];
    logic [W-1:0]  exp_w[$];
    int            tests_run = 0;
    int            tests_failed = 0;
    int            delivered = 0;
    int            delivered_w = 0;
    logic [W-1:0]  last_w = '0;

    always #5 clk = ~clk;

    fib_stream_buffer #(.WIDTH(W), .DEPTH(D), .N_TERMS(25)) dut (
        .clk(clk), .rst(rst), .start(start), .f_en(f_en), .f_valid(f_valid),
        .f_out(f_out), .m_valid(m_valid), .m_data(m_data), .m_ready(m_ready),
        .count(count), .busy(busy), .done(done), .wrap_err(wrap_err)
    );

    fib_stream_buffer #(.WIDTH(W), .DEPTH(D), .N_TERMS(30)) dut_w (
        .clk(clk), .rst(rst), .start(start_w), .f_en(f_en_w), .f_valid(f_valid_w),
        .f_out(f_out_w), .m_valid(m_valid_w), .m_data(m_data_w), .m_ready(m_ready_w),
        .count(count_w), .busy(busy_w), .done(done_w), .wrap_err(wrap_err_w)
    );

    // External generators: emit a while enabled, hold otherwise.
    assign f_valid   = f_en;
    assign f_out     = ga;
    assign f_valid_w = f_en_w;
    assign f_out_w   = ga_w;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ga <= '0; gb <= 16'd1; ga_w <= '0; gb_w <= 16'd1;
        end else begin
            if (f_en)   begin ga   <= gb;   gb   <= ga + gb;     end
            if (f_en_w) begin ga_w <= gb_w; gb_w <= ga_w + gb_w; end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        tests_run++;
        if (act !== expv) begin
            tests_failed++;
            $display("FAIL %s: got %0d expected %0d", name, act, expv);
        end
    endtask

    // Reference: Fibonacci mod 2^16, stopping at n_terms or at the first decrease.
    task automatic load_expected(input int n_terms, input bit wrap_inst);
        int a, b, t, prev;
        a = 0; b = 1; prev = 0;
        for (int k = 0; k < n_terms; k++) begin
            if (k >= 2 && a < prev) break;
            if (wrap_inst) exp_w.push_back(W'(a)); else exp_q.push_back(W'(a));
            prev = a;
            t = (a + b) % 65536;
            a = b;
            b = t;
        end
    endtask

    always @(negedge clk) begin
        if (!rst && m_valid && m_ready) begin
            if (exp_q.size() == 0) check("unexpected_term", 32'(m_data), 32'hFFFF_FFFF);
            else check("term_order", 32'(m_data), 32'(exp_q.pop_front()));
            delivered++;
        end
        if (!rst && m_valid_w && m_ready_w) begin
            if (exp_w.size() == 0) check("unexpected_term_w", 32'(m_data_w), 32'hFFFF_FFFF);
            else check("term_order_w", 32'(m_data_w), 32'(exp_w.pop_front()));
            delivered_w++;
            last_w = m_data_w;
        end
    end

    task automatic pulse_start();
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
    endtask

    task automatic do_reset();
        @(posedge clk); #1 rst = 1'b1;
        exp_q.delete(); exp_w.delete();
        delivered = 0; delivered_w = 0;
        @(posedge clk); #1 rst = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_f_en"}, 32'(f_en), 0);
        check({tag, "_m_valid"}, 32'(m_valid), 0);
        check({tag, "_m_data"}, 32'(m_data), 0);
        check({tag, "_count"}, 32'(count), 0);
        check({tag, "_busy"}, 32'(busy), 0);
        check({tag, "_done"}, 32'(done), 0);
        check({tag, "_wrap_err"}, 32'(wrap_err), 0);
    endtask

    task automatic wait_drain(input string tag, input bit rnd, input int budget);
        int i;
        for (i = 0; i < budget; i++) begin
            @(posedge clk); #1;
            if (rnd) m_ready = 1'($urandom_range(0, 1));
            @(negedge clk);
            check({tag, "_count_range"}, 32'(count <= CW'(D)), 1);
            if (done && exp_q.size() == 0 && !m_valid) break;
        end
        if (i == budget) check({tag, "_drain_timeout"}, 32'(exp_q.size()), 0);
        m_ready = 1'b1;
    endtask

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_all_zero("in_reset");
        #1 rst = 1'b0;
        @(negedge clk);
        check_all_zero("after_reset");

        // Full run with m_ready high: one term per cycle, 25 terms.
        load_expected(25, 1'b0);
        m_ready = 1'b1;
        pulse_start();
        @(negedge clk);
        check("a_f_en_after_start", 32'(f_en), 1);
        check("a_busy", 32'(busy), 1);
        check("a_first_not_yet", 32'(m_valid), 0);
        @(negedge clk);
        check("a_first_valid", 32'(m_valid), 1);
        check("a_first_data", 32'(m_data), 0);
        wait_drain("a", 1'b0, 200);
        check("a_done", 32'(done), 1);
        check("a_wrap_err", 32'(wrap_err), 0);
        check("a_f_en_low", 32'(f_en), 0);
        check("a_delivered", 32'(delivered), 25);
        pulse_start();
        repeat (3) @(negedge clk);
        check("a_start_in_done_busy", 32'(busy), 0);
        check("a_start_in_done_done", 32'(done), 1);
        check("a_start_in_done_count", 32'(count), 0);

        // Backpressure: fill, single pop, toggling, then random drain.
        do_reset();
        load_expected(25, 1'b0);
        m_ready = 1'b0;
        pulse_start();
        repeat (20) @(negedge clk);
        check("b_count_full", 32'(count), 8);
        check("b_f_en_low", 32'(f_en), 0);
        check("b_busy", 32'(busy), 1);
        pulse_start();
        repeat (2) @(negedge clk);
        check("b_start_in_run_count", 32'(count), 8);
        check("b_start_in_run_busy", 32'(busy), 1);
        check("b_start_in_run_head", 32'(m_data), 0);
        @(posedge clk); #1 m_ready = 1'b1;
        @(posedge clk); #1 m_ready = 1'b0;
        @(negedge clk);
        check("b_f_en_resume", 32'(f_en), 1);
        check("b_count_after_pop", 32'(count), 7);
        @(negedge clk);
        check("b_count_refill", 32'(count), 8);
        check("b_f_en_drop", 32'(f_en), 0);
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1 m_ready = ~m_ready;
            @(negedge clk);
            check("b_toggle_count_range", 32'(count <= CW'(D)), 1);
        end
        wait_drain("b", 1'b1, 600);
        check("b_done", 32'(done), 1);
        check("b_delivered", 32'(delivered), 25);

        // Asynchronous reset in the middle of a run.
        do_reset();
        load_expected(25, 1'b0);
        m_ready = 1'b0;
        pulse_start();
        begin
            int i;
            for (i = 0; i < 50; i++) begin
                @(negedge clk);
                if (count == CW'(5)) break;
            end
            if (i == 50) check("c_reach_five_timeout", 32'(count), 5);
        end
        #2 rst = 1'b1;
        #1 check_all_zero("c_mid_reset");
        exp_q.delete();
        delivered = 0;
        @(posedge clk); #1 rst = 1'b0;
        load_expected(25, 1'b0);
        m_ready = 1'b1;
        pulse_start();
        wait_drain("c", 1'b1, 600);
        check("c_done", 32'(done), 1);
        check("c_delivered", 32'(delivered), 25);

        // N_TERMS=30 instance stops on the 16-bit wrap after 46368.
        load_expected(30, 1'b1);
        check("d_model_len", 32'(exp_w.size()), 25);
        @(posedge clk); #1 start_w = 1'b1;
        @(posedge clk); #1 start_w = 1'b0;
        begin
            int i;
            for (i = 0; i < 300; i++) begin
                @(negedge clk);
                if (done_w && exp_w.size() == 0 && !m_valid_w) break;
            end
            if (i == 300) check("d_drain_timeout", 32'(exp_w.size()), 0);
        end
        check("d_wrap_err", 32'(wrap_err_w), 1);
        check("d_done", 32'(done_w), 1);
        check("d_delivered", 32'(delivered_w), 25);
        check("d_last_term", 32'(last_w), 46368);
        check("d_f_en_low", 32'(f_en_w), 0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
